// File: rtl/prl_tx_retry_pkg.sv
// Shared definitions for the USB-PD protocol-layer transmit path: FSM encodings,
// SOP type codes, header MessageID field position and byte-count legality.
package prl_tx_retry_pkg;

    localparam logic [3:0] ST_WAIT_REQ       = 4'd0;
    localparam logic [3:0] ST_RESET_RETRY    = 4'd1;
    localparam logic [3:0] ST_CONSTRUCT      = 4'd2;
    localparam logic [3:0] ST_SEND           = 4'd3;
    localparam logic [3:0] ST_WAIT_PHY       = 4'd4;
    localparam logic [3:0] ST_MATCH_ID       = 4'd5;
    localparam logic [3:0] ST_CHECK_RETRY    = 4'd6;
    localparam logic [3:0] ST_REPORT_FAIL    = 4'd7;
    localparam logic [3:0] ST_REPORT_SUCCESS = 4'd8;

    typedef enum logic [2:0] {
        SOP_SOP        = 3'd0,
        SOP_SOP_P      = 3'd1,
        SOP_SOP_PP     = 3'd2,
        SOP_DBG_P      = 3'd3,
        SOP_DBG_PP     = 3'd4,
        SOP_HARD_RESET = 3'd5
    } sop_e;

    localparam logic [2:0] SOP_LAST_LEGAL = 3'(SOP_HARD_RESET);

    // MessageID occupies header bits [11:9], i.e. HEADER_HIGH[3:1]
    localparam int MSGID_LSB = 9;
    localparam int MSGID_W   = 3;

    function automatic logic byte_count_ok(input logic [7:0] cnt, input int max_obj);
        return (cnt[0] == 1'b0) && (cnt >= 8'd2) && (int'(cnt) <= 2 + 4 * max_obj);
    endfunction

endpackage

// File: rtl/prl_tx_retry_if.sv
// Policy-engine request, GoodCRC feedback and PHY byte-stream signals of the
// transmit engine; slave is the engine, master is whoever drives it.
interface prl_tx_retry_if #(
    parameter int MAX_OBJECTS = 7
);
    localparam int DATA_W = 32 * MAX_OBJECTS;

    logic              transmit_valid;
    logic [2:0]        transmit;
    logic [7:0]        byte_count;
    logic [7:0]        header_low;
    logic [7:0]        header_high;
    logic [DATA_W-1:0] data_objects;
    logic              goodcrc_response;
    logic [2:0]        goodcrc_msg_id;
    logic [7:0]        phy_tx_data;
    logic              phy_tx_valid;
    logic              phy_tx_ready;
    logic [2:0]        phy_tx_sop;
    logic              tx_busy;
    logic              tx_success;
    logic              tx_failure;
    logic [2:0]        message_id_counter;
    logic [2:0]        retry_count;

    modport slave (
        input  transmit_valid, transmit, byte_count, header_low, header_high,
               data_objects, goodcrc_response, goodcrc_msg_id, phy_tx_ready,
        output phy_tx_data, phy_tx_valid, phy_tx_sop, tx_busy, tx_success,
               tx_failure, message_id_counter, retry_count
    );

    modport master (
        output transmit_valid, transmit, byte_count, header_low, header_high,
               data_objects, goodcrc_response, goodcrc_msg_id, phy_tx_ready,
        input  phy_tx_data, phy_tx_valid, phy_tx_sop, tx_busy, tx_success,
               tx_failure, message_id_counter, retry_count
    );

endinterface

// File: rtl/prl_crc_timer.sv
// Loadable down-counter for the CRCReceiveTimer; shared with the receive path.
module prl_crc_timer #(
    parameter int CRC_TIMEOUT = 900
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int TW = $clog2(CRC_TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TW'(CRC_TIMEOUT);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the cycle whose decrement takes the count to zero, so a load of N
    // gives exactly N enabled cycles before expiry.
    assign expired_o = en_i && (cnt_q <= TW'(1));

endmodule

// File: rtl/prl_tx_retry.sv
// USB-PD protocol-layer transmit engine: builds the message, streams it to the
// PHY, waits for a matching GoodCRC with bounded retries and owns the MessageID.
module prl_tx_retry
    import prl_tx_retry_pkg::*;
#(
    parameter int MAX_OBJECTS = 7,
    parameter int N_RETRY     = 3,
    parameter int CRC_TIMEOUT = 900
) (
    input  logic           clk_i,
    input  logic           rst_i,
    prl_tx_retry_if.slave  bus_if
);
    // state          | meaning
    // WAIT_REQ       | idle, waiting for a legal request
    // RESET_RETRY    | clear retry count, vet byte count
    // CONSTRUCT      | insert MessageID into header, rewind byte index
    // SEND           | stream bytes to PHY
    // WAIT_PHY       | CRCReceiveTimer running, waiting for GoodCRC
    // MATCH_ID       | compare GoodCRC MessageID with counter
    // CHECK_RETRY    | retransmit or give up
    // REPORT_FAIL    | TX_FAILURE pulse, bump MessageID
    // REPORT_SUCCESS | TX_SUCCESS pulse, bump MessageID

    localparam int NBYTES = 2 + 4 * MAX_OBJECTS;
    localparam int BUF_W  = 8 * NBYTES;

    logic [3:0]       state_q, state_d;
    logic [2:0]       msg_id_q, msg_id_d;
    logic [2:0]       retry_q, retry_d;
    logic [2:0]       sop_q, sop_d;
    logic [7:0]       count_q, count_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [4:0]       idx_q, idx_d;
    logic [2:0]       crc_id_q, crc_id_d;
    logic             timer_load;
    logic             timer_en;
    logic             timer_expired;

    prl_crc_timer #(
        .CRC_TIMEOUT (CRC_TIMEOUT)
    ) u_crc_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (timer_load),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        msg_id_d   = msg_id_q;
        retry_d    = retry_q;
        sop_d      = sop_q;
        count_d    = count_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        crc_id_d   = crc_id_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        case (state_q)
            ST_WAIT_REQ: begin
                if (bus_if.transmit_valid && (bus_if.transmit <= SOP_LAST_LEGAL)) begin
                    sop_d   = bus_if.transmit;
                    count_d = bus_if.byte_count;
                    // Wire order of the buffer matches transmission order, byte 0 in the LSBs
                    buf_d   = {bus_if.data_objects, bus_if.header_high, bus_if.header_low};
                    state_d = ST_RESET_RETRY;
                end
            end
            ST_RESET_RETRY: begin
                retry_d = '0;
                state_d = byte_count_ok(count_q, MAX_OBJECTS) ? ST_CONSTRUCT : ST_REPORT_FAIL;
            end
            ST_CONSTRUCT: begin
                buf_d[MSGID_LSB +: MSGID_W] = msg_id_q;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus_if.phy_tx_ready) begin
                    if ({3'b000, idx_q} == (count_q - 8'd1)) begin
                        timer_load = 1'b1;
                        state_d    = ST_WAIT_PHY;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_WAIT_PHY: begin
                timer_en = 1'b1;
                if (bus_if.goodcrc_response) begin
                    crc_id_d = bus_if.goodcrc_msg_id;
                    state_d  = ST_MATCH_ID;
                end else if (timer_expired) begin
                    state_d = ST_CHECK_RETRY;
                end
            end
            ST_MATCH_ID: begin
                state_d = (crc_id_q == msg_id_q) ? ST_REPORT_SUCCESS : ST_CHECK_RETRY;
            end
            ST_CHECK_RETRY: begin
                if (retry_q < 3'(N_RETRY)) begin
                    retry_d = retry_q + 3'd1;
                    state_d = ST_CONSTRUCT;
                end else begin
                    state_d = ST_REPORT_FAIL;
                end
            end
            ST_REPORT_FAIL, ST_REPORT_SUCCESS: begin
                msg_id_d = msg_id_q + 3'd1;
                state_d  = ST_WAIT_REQ;
            end
            default: begin
                state_d = ST_WAIT_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_WAIT_REQ;
            msg_id_q <= '0;
            retry_q  <= '0;
            sop_q    <= '0;
            count_q  <= '0;
            buf_q    <= '0;
            idx_q    <= '0;
            crc_id_q <= '0;
        end else begin
            state_q  <= state_d;
            msg_id_q <= msg_id_d;
            retry_q  <= retry_d;
            sop_q    <= sop_d;
            count_q  <= count_d;
            buf_q    <= buf_d;
            idx_q    <= idx_d;
            crc_id_q <= crc_id_d;
        end
    end

    // Outputs decode the registered state, so reset clears them without waiting for a clock
    assign bus_if.phy_tx_valid       = (state_q == ST_SEND);
    assign bus_if.phy_tx_data        = bus_if.phy_tx_valid ? buf_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign bus_if.phy_tx_sop         = sop_q;
    assign bus_if.tx_busy            = (state_q != ST_WAIT_REQ);
    assign bus_if.tx_success         = (state_q == ST_REPORT_SUCCESS);
    assign bus_if.tx_failure         = (state_q == ST_REPORT_FAIL);
    assign bus_if.message_id_counter = msg_id_q;
    assign bus_if.retry_count        = retry_q;

endmodule

// File: tb/tb_prl_tx_retry.sv
// Scoreboard bench for prl_tx_retry: expected PHY bytes and report pulses are
// queued by the stimulus and consumed by a negedge monitor.
module tb_prl_tx_retry;

    localparam int MAX_OBJ = 7;
    localparam int NRET    = 3;
    localparam int TMO     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prl_tx_retry_if #(.MAX_OBJECTS(MAX_OBJ)) bus_if ();

    prl_tx_retry #(
        .MAX_OBJECTS (MAX_OBJ),
        .N_RETRY     (NRET),
        .CRC_TIMEOUT (TMO)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus_if)
    );

    typedef struct {
        logic       ok;
        logic [2:0] retry;
        logic [2:0] id;
    } rep_t;

    logic [7:0] exp_bytes [$];
    rep_t       exp_rep [$];
    rep_t       mon_rep;
    int         passed = 0;
    int         total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.phy_tx_valid && bus_if.phy_tx_ready) begin
                check("byte_expected", 32'(exp_bytes.size() != 0), 32'd1);
                if (exp_bytes.size() != 0)
                    check("phy_byte", 32'(bus_if.phy_tx_data), 32'(exp_bytes.pop_front()));
            end
            if (bus_if.tx_success || bus_if.tx_failure) begin
                check("pulse_exclusive", 32'(bus_if.tx_success & bus_if.tx_failure), 32'd0);
                check("report_expected", 32'(exp_rep.size() != 0), 32'd1);
                if (exp_rep.size() != 0) begin
                    mon_rep = exp_rep.pop_front();
                    check("report_kind", 32'(bus_if.tx_success), 32'(mon_rep.ok));
                    check("report_retry", 32'(bus_if.retry_count), 32'(mon_rep.retry));
                    check("report_msgid", 32'(bus_if.message_id_counter), 32'(mon_rep.id));
                end
            end
        end
    end

    // Bytes listed first-to-last as a concatenation, right-aligned in v
    task automatic push_msg(input int n, input logic [79:0] v);
        for (int i = 0; i < n; i++) exp_bytes.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic push_rep(input logic ok, input logic [2:0] retry, input logic [2:0] id);
        rep_t r;
        r.ok = ok; r.retry = retry; r.id = id;
        exp_rep.push_back(r);
    endtask

    task automatic send_req(input logic [2:0] sop, input logic [7:0] cnt, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [223:0] objs);
        bus_if.transmit       = sop;
        bus_if.byte_count     = cnt;
        bus_if.header_high    = hi;
        bus_if.header_low     = lo;
        bus_if.data_objects   = objs;
        bus_if.transmit_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.transmit_valid = 1'b0;
    endtask

    // Returns in the first WAIT_PHY cycle
    task automatic wait_bytes_done();
        int n = 0;
        while (exp_bytes.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("bytes_drained", 32'(exp_bytes.size()), 32'd0);
    endtask

    task automatic wait_report_done();
        int n = 0;
        while (exp_rep.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("report_arrived", 32'(exp_rep.size()), 32'd0);
    endtask

    // Pulse GoodCRC in WAIT_PHY cycle cyc (called in cycle 1)
    task automatic crc_pulse(input logic [2:0] id, input int cyc);
        for (int i = 1; i < cyc; i++) begin
            @(posedge clk); #1;
        end
        bus_if.goodcrc_response = 1'b1;
        bus_if.goodcrc_msg_id   = id;
        @(posedge clk); #1;
        bus_if.goodcrc_response = 1'b0;
    endtask

    initial begin
        int n;
        bus_if.transmit_valid   = 1'b0;
        bus_if.transmit         = '0;
        bus_if.byte_count       = '0;
        bus_if.header_low       = '0;
        bus_if.header_high      = '0;
        bus_if.data_objects     = '0;
        bus_if.goodcrc_response = 1'b0;
        bus_if.goodcrc_msg_id   = '0;
        bus_if.phy_tx_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy",    32'(bus_if.tx_busy), 32'd0);
        check("rst_valid",   32'(bus_if.phy_tx_valid), 32'd0);
        check("rst_success", 32'(bus_if.tx_success), 32'd0);
        check("rst_failure", 32'(bus_if.tx_failure), 32'd0);
        check("rst_msgid",   32'(bus_if.message_id_counter), 32'd0);
        check("rst_retry",   32'(bus_if.retry_count), 32'd0);

        // Single object, ID 0, GoodCRC in WAIT_PHY cycle 10
        push_msg(6, 80'({8'h61, 8'h11, 8'hAA, 8'hBB, 8'hCC, 8'hDD}));
        push_rep(1'b1, 3'd0, 3'd0);
        send_req(3'd1, 8'd6, 8'h11, 8'h61, 224'(32'hDDCCBBAA));
        n = 1;
        while (!bus_if.phy_tx_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("req_latency", 32'(n), 32'd3);
        wait_bytes_done();
        crc_pulse(3'd0, 10);
        wait_report_done();
        check("t1_msgid", 32'(bus_if.message_id_counter), 32'd1);
        check("t1_sop",   32'(bus_if.phy_tx_sop), 32'd1);

        // Timeout, then success on the retransmission
        push_msg(10, 80'({8'h4A, 8'hF3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}));
        push_rep(1'b1, 3'd1, 3'd1);
        send_req(3'd0, 8'd10, 8'hFF, 8'h4A, 224'({32'h07060504, 32'h03020100}));
        wait_bytes_done();
        push_msg(10, 80'({8'h4A, 8'hF3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}));
        n = 0;
        while (!bus_if.phy_tx_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("retry_gap",   32'(n), 32'd18);
        check("retry_count", 32'(bus_if.retry_count), 32'd1);
        wait_bytes_done();
        crc_pulse(3'd1, 3);
        wait_report_done();
        check("t2_msgid", 32'(bus_if.message_id_counter), 32'd2);

        // Never answered: four transmissions then failure
        push_rep(1'b0, 3'd3, 3'd2);
        send_req(3'd2, 8'd2, 8'h00, 8'h00, 224'd0);
        for (int a = 0; a < 4; a++) begin
            push_msg(2, 80'({8'h00, 8'h04}));
            wait_bytes_done();
        end
        wait_report_done();
        check("t3_msgid", 32'(bus_if.message_id_counter), 32'd3);
        repeat (30) @(posedge clk);
        #1;

        // Odd byte count fails without PHY activity
        push_rep(1'b0, 3'd0, 3'd3);
        send_req(3'd0, 8'd5, 8'h00, 8'h00, 224'd0);
        @(posedge clk); #1;
        check("odd_count_fail", 32'(bus_if.tx_failure), 32'd1);
        wait_report_done();
        check("t4_msgid", 32'(bus_if.message_id_counter), 32'd4);

        // Reserved SOP type is ignored
        send_req(3'd6, 8'd6, 8'h00, 8'h00, 224'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reserved_sop_busy",  32'(bus_if.tx_busy), 32'd0);
        check("reserved_sop_msgid", 32'(bus_if.message_id_counter), 32'd4);

        // Byte count one step past the maximum
        push_rep(1'b0, 3'd0, 3'd4);
        send_req(3'd0, 8'd32, 8'h00, 8'h00, 224'd0);
        wait_report_done();
        check("t6_msgid", 32'(bus_if.message_id_counter), 32'd5);

        // Mismatched GoodCRC ID forces a retry
        push_msg(6, 80'({8'h22, 8'h0A, 8'h44, 8'h33, 8'h22, 8'h11}));
        push_rep(1'b1, 3'd1, 3'd5);
        send_req(3'd0, 8'd6, 8'h00, 8'h22, 224'(32'h11223344));
        wait_bytes_done();
        crc_pulse(3'd4, 2);
        push_msg(6, 80'({8'h22, 8'h0A, 8'h44, 8'h33, 8'h22, 8'h11}));
        wait_bytes_done();
        crc_pulse(3'd5, 1);
        wait_report_done();
        check("t7_msgid", 32'(bus_if.message_id_counter), 32'd6);

        push_msg(2, 80'({8'h00, 8'h0C}));
        push_rep(1'b1, 3'd0, 3'd6);
        send_req(3'd0, 8'd2, 8'h00, 8'h00, 224'd0);
        wait_bytes_done();
        crc_pulse(3'd6, 5);
        wait_report_done();
        check("t8_msgid", 32'(bus_if.message_id_counter), 32'd7);

        // Back-pressure mid-message, then success wraps the counter
        push_msg(6, 80'({8'h5A, 8'h8E, 8'h0D, 8'hF0, 8'hFE, 8'hCA}));
        push_rep(1'b1, 3'd0, 3'd7);
        send_req(3'd3, 8'd6, 8'h80, 8'h5A, 224'(32'hCAFEF00D));
        n = 0;
        while (exp_bytes.size() > 4 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("stall_reach", 32'(exp_bytes.size()), 32'd4);
        bus_if.phy_tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #2;
            check("stall_data",  32'(bus_if.phy_tx_data), 32'h0D);
            check("stall_valid", 32'(bus_if.phy_tx_valid), 32'd1);
            @(posedge clk); #1;
        end
        bus_if.phy_tx_ready = 1'b1;
        wait_bytes_done();
        crc_pulse(3'd7, 4);
        wait_report_done();
        check("wrap_msgid", 32'(bus_if.message_id_counter), 32'd0);

        // GoodCRC in the final timer cycle still counts
        push_msg(2, 80'({8'h11, 8'h20}));
        push_rep(1'b1, 3'd0, 3'd0);
        send_req(3'd4, 8'd2, 8'h22, 8'h11, 224'd0);
        wait_bytes_done();
        crc_pulse(3'd0, TMO);
        wait_report_done();
        check("t10_msgid", 32'(bus_if.message_id_counter), 32'd1);

        // Reset during SEND abandons the message silently
        push_msg(10, 80'({8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}));
        send_req(3'd0, 8'd10, 8'h00, 8'h00, 224'd0);
        n = 0;
        while (exp_bytes.size() > 7 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("mid_send_reach", 32'(exp_bytes.size()), 32'd7);
        rst = 1'b1;
        #1;
        check("rst_drop_valid", 32'(bus_if.phy_tx_valid), 32'd0);
        check("rst_drop_busy",  32'(bus_if.tx_busy), 32'd0);
        check("rst_drop_msgid", 32'(bus_if.message_id_counter), 32'd0);
        exp_bytes.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("no_pending_report", 32'(exp_rep.size()), 32'd0);
        check("idle_after_reset",  32'(bus_if.tx_busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
